// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the CPU store path (req0) and a debug/trace source (req1).
// Optional packet lock is enabled with `define UART_ARB_PACKET_LOCK_EN.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no byte held; selected requester sees ready, accept on edge
//   SEND  | byte held on uart_data with uart_valid=1 until uart_ready
module uart_tx_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    input  logic       uart_ready,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    logic   rr;
    logic   allow0;
    logic   allow1;
    logic   cand0;
    logic   cand1;
    logic   sel_valid;
    logic   sel_id;

`ifdef UART_ARB_PACKET_LOCK_EN
    logic        locked;
    logic [15:0] idle_cnt;
    logic        owner_valid;

    // While locked, only the owner of the last transferred byte may be selected.
    assign allow0      = !locked || (grant_id == 1'b0);
    assign allow1      = !locked || (grant_id == 1'b1);
    assign owner_valid = grant_id ? req1_valid : req0_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked   <= 1'b0;
            idle_cnt <= 16'd0;
        end else if (state == IDLE) begin
            if (sel_valid) begin
                idle_cnt <= 16'd0;
            end else if (locked && !owner_valid) begin
                if ((32'(idle_cnt) + 32'd1) >= LOCK_TIMEOUT)
                    locked <= 1'b0;
                if (idle_cnt != 16'hFFFF)
                    idle_cnt <= idle_cnt + 16'd1;
            end
        end else if (uart_ready) begin
            locked <= (uart_data != 8'h0A);
        end
    end
`else
    logic unused_lock_timeout;

    assign allow0              = 1'b1;
    assign allow1              = 1'b1;
    assign unused_lock_timeout = (LOCK_TIMEOUT == 32'd0);
`endif

    always_comb begin
        cand0     = req0_valid && allow0;
        cand1     = req1_valid && allow1;
        sel_valid = (state == IDLE) && (cand0 || cand1);
        sel_id    = (cand0 && cand1) ? rr : cand1;
    end

    assign req0_ready = sel_valid && !sel_id;
    assign req1_ready = sel_valid && sel_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr         <= 1'b0;
            uart_data  <= 8'h00;
            uart_valid <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        uart_data  <= sel_id ? req1_data : req0_data;
                        grant_id   <= sel_id;
                        uart_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (uart_ready) begin
                        uart_valid <= 1'b0;
                        busy       <= 1'b0;
                        rr         <= ~grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps followed by a randomized run checked against a transaction-level model.
module tb_uart_tx_arbiter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, uart_ready;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [7:0] uart_data;
    logic       uart_valid, busy, grant_id;

    int n_cmp = 0;
    int n_err = 0;

    // model: whether a byte is held, which byte/source, who is preferred, lock owner info
    logic       m_send, m_gid, m_rr, m_locked;
    logic [7:0] m_byte;
    int         m_idle_low;

    uart_tx_arbiter #(.LOCK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .uart_ready (uart_ready),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_send = 1'b0; m_gid = 1'b0; m_rr = 1'b0; m_locked = 1'b0;
        m_byte = 8'h00; m_idle_low = 0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; uart_ready = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Expected selection from the arbitration rules applied to the current inputs.
    task automatic model_sel(output logic ok, output logic id);
        logic e0, e1;
        e0 = req0_valid;
        e1 = req1_valid;
`ifdef UART_ARB_PACKET_LOCK_EN
        if (m_locked && m_idle_low < TO) begin
            if (m_gid) e0 = 1'b0;
            else       e1 = 1'b0;
        end
`endif
        ok = !m_send && (e0 || e1);
        id = (e0 && e1) ? m_rr : e1;
    endtask

    logic [7:0] bytes_seen [8];
    logic       gids_seen  [8];
    logic [7:0] seq0 [3];

    initial begin
        int  got, idx, cnt;
        logic a0, found, ok, id, acc0, acc1;

        reset = 1'b0;
        model_reset();
        reset_dut();

        // reset values
        #1;
        chk("rst_uart_valid", 8'(uart_valid), 8'h00);
        chk("rst_uart_data",  uart_data,      8'h00);
        chk("rst_busy",       8'(busy),       8'h00);
        chk("rst_grant_id",   8'(grant_id),   8'h00);
        chk("rst_req0_ready", 8'(req0_ready), 8'h00);
        chk("rst_req1_ready", 8'(req1_ready), 8'h00);

        // single requester
        req0_valid = 1'b1; req0_data = 8'h41; uart_ready = 1'b1;
        #1;
        chk("single_req0_ready", 8'(req0_ready), 8'h01);
        chk("single_req1_ready", 8'(req1_ready), 8'h00);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_uart_valid", 8'(uart_valid), 8'h01);
        chk("single_uart_data",  uart_data,      8'h41);
        chk("single_grant_id",   8'(grant_id),   8'h00);
        chk("single_busy",       8'(busy),       8'h01);
        @(negedge clk);
        chk("single_back_idle", 8'(uart_valid), 8'h00);
        chk("single_busy_idle", 8'(busy),       8'h00);

        // fair arbitration
        reset_dut();
        req0_valid = 1'b1; req0_data = 8'h30;
        req1_valid = 1'b1; req1_data = 8'h31;
        uart_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (uart_valid) begin
                bytes_seen[got] = uart_data;
                gids_seen[got]  = grant_id;
                got++;
            end
        end
        chk("fair_count", 8'(got), 8'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair_data%0d", i), bytes_seen[i], (i % 2 == 1) ? 8'h31 : 8'h30);
            chk($sformatf("fair_gid%0d", i),  8'(gids_seen[i]), 8'(i % 2));
        end

        // back-pressure, with req1 waiting
        reset_dut();
        req0_valid = 1'b1; req0_data = 8'h5A; uart_ready = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hC3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_uart_valid", 8'(uart_valid), 8'h01);
            chk("bp_uart_data",  uart_data,      8'h5A);
            chk("bp_busy",       8'(busy),       8'h01);
            chk("bp_req0_ready", 8'(req0_ready), 8'h00);
            chk("bp_req1_ready", 8'(req1_ready), 8'h00);
        end
        uart_ready = 1'b1;
        @(negedge clk);
        chk("bp_released_valid", 8'(uart_valid), 8'h00);
        chk("bp_req1_next",      8'(req1_ready), 8'h01);

        // reset mid-transfer
        uart_ready = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        #2;
        chk("mid_in_send", 8'(uart_valid), 8'h01);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(uart_valid), 8'h00);
        chk("mid_rst_busy",  8'(busy),       8'h00);
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_after_req0", 8'(req0_ready), 8'h01);
        chk("mid_after_req1", 8'(req1_ready), 8'h00);

`ifdef UART_ARB_PACKET_LOCK_EN
        // packet lock: req1 waits for the newline from req0
        reset_dut();
        seq0[0] = 8'h41; seq0[1] = 8'h42; seq0[2] = 8'h0A;
        idx = 0;
        req0_valid = 1'b1; req0_data = seq0[0];
        req1_valid = 1'b1; req1_data = 8'h77;
        uart_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            a0 = req0_ready;
            if (uart_valid) begin
                bytes_seen[got] = uart_data;
                gids_seen[got]  = grant_id;
                got++;
            end
            @(posedge clk); #1;
            if (a0) idx++;
            req0_valid = (idx < 3);
            req0_data  = (idx < 3) ? seq0[idx] : 8'h00;
        end
        req1_valid = 1'b0;
        chk("lock_count", 8'(got), 8'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lock_data%0d", i), bytes_seen[i], (i < 3) ? seq0[i] : 8'h77);
            chk($sformatf("lock_gid%0d", i),  8'(gids_seen[i]), (i < 3) ? 8'h00 : 8'h01);
        end

        // lock timeout
        reset_dut();
        req0_valid = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b1; req1_data = 8'h77;
        uart_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (req1_ready) found = 1'b1;
            else if (!uart_valid) cnt++;
        end
        chk("timeout_granted", 8'(found), 8'h01);
        chk("timeout_cycles",  8'(cnt),   8'(TO));
`endif

        // randomized run against the model
        reset_dut();
        @(posedge clk); #1;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (acc0 || !req0_valid || ($urandom % 10 == 0)) begin
                req0_valid = ($urandom % 3 != 0);
                req0_data  = ($urandom % 4 == 0) ? 8'h0A : 8'($urandom);
            end
            if (acc1 || !req1_valid || ($urandom % 10 == 0)) begin
                req1_valid = ($urandom % 3 != 0);
                req1_data  = ($urandom % 4 == 0) ? 8'h0A : 8'($urandom);
            end
            uart_ready = ($urandom % 2 == 0);
            @(negedge clk);
            model_sel(ok, id);
            chk("rnd_req0_ready", 8'(req0_ready), 8'(ok && !id));
            chk("rnd_req1_ready", 8'(req1_ready), 8'(ok && id));
            chk("rnd_uart_valid", 8'(uart_valid), 8'(m_send));
            chk("rnd_busy",       8'(busy),       8'(m_send));
            chk("rnd_uart_data",  uart_data,      m_byte);
            chk("rnd_grant_id",   8'(grant_id),   8'(m_gid));
            acc0 = ok && !id;
            acc1 = ok && id;
            if (!m_send) begin
                if (ok) begin
                    m_send = 1'b1;
                    m_byte = id ? req1_data : req0_data;
                    m_gid  = id;
                    m_idle_low = 0;
                end else if (!(m_gid ? req1_valid : req0_valid)) begin
                    m_idle_low++;
                end
            end else if (uart_ready) begin
                m_send   = 1'b0;
                m_rr     = ~m_gid;
                m_locked = (m_byte != 8'h0A);
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
